cell_stim_capture: RTL and testbench

- Wishbone-programmable stimulus generator and response compactor for the standard-cell test harness.
- Sits directly upstream of the cell-under-test array. It drives an exhaustive input-vector sweep onto cell inputs and samples the cell outputs once per vector.
- It compacts the responses into a 32-bit MISR signature that firmware reads back, so a full truth table is verified with one register read instead of per-pin checks.

---
 rtl/cell_stim_pkg.sv | 26 ++
 rtl/cell_stim_capture_if.sv | 21 ++
 rtl/cell_stim_misr.sv | 39 +++
 rtl/cell_stim_capture.sv | 186 ++++++++++++++++++
 tb/tb_cell_stim_capture.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cell_stim_pkg.sv
// Shared constants, state encoding and MISR step function for the stimulus/capture block.
package cell_stim_pkg;

  // Register offsets within the 256-byte decode window
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_SETTLE   = 8'h04;
  localparam logic [7:0] OFF_LAST_VEC = 8'h08;
  localparam logic [7:0] OFF_SIG      = 8'h0C;
  localparam logic [7:0] OFF_RESP     = 8'h10;
  localparam logic [7:0] OFF_VEC      = 8'h14;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  // One MISR step: Galois shift with feedback, then fold in the new response
  function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] data);
    return ({sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0)) ^ data;
  endfunction

endpackage

// File: rtl/cell_stim_capture_if.sv
// Wishbone slave bus bundle for cell_stim_capture.
interface cell_stim_capture_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/cell_stim_misr.sv
// 32-bit multiple-input signature register with seed load and step controls.
module cell_stim_misr
  import cell_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_data,
  output logic [31:0] o_sig
);

  logic [31:0] r_sig;
  logic [31:0] w_sig_d;

  // Load wins over step so a restart always begins from the seed
  always_comb begin
    w_sig_d = r_sig;
    if (i_load) begin
      w_sig_d = SEED;
    end else if (i_step) begin
      w_sig_d = misr_next(r_sig, i_data);
    end
  end

  // Signature register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig <= SEED;
    end else begin
      r_sig <= w_sig_d;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/cell_stim_capture.sv
// Wishbone-programmable exhaustive stimulus sweep with MISR response compaction.
module cell_stim_capture
  import cell_stim_pkg::*;
#(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned NUM_OUT   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] SEED      = 32'hFFFF_FFFF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  cell_stim_capture_if.slave wbs,
  output logic [NUM_IN-1:0]  stim_o,
  input  logic [NUM_OUT-1:0] resp_i,
  output logic               busy_o,
  output logic               done_o
);

  state_e             r_state, w_state_d;
  logic [7:0]         r_cnt, w_cnt_d;
  logic [NUM_IN-1:0]  r_vec, w_vec_d;
  logic [NUM_IN-1:0]  r_stim, w_stim_d;
  logic [NUM_OUT-1:0] r_resp, w_resp_d;
  logic               r_done, w_done_d;
  logic [7:0]         r_settle;
  logic [NUM_IN-1:0]  r_last_vec;
  logic               r_ack;
  logic [31:0]        r_dat;

  logic [7:0]        w_off;
  logic              w_hit, w_req, w_wr;
  logic              w_start, w_abort, w_busy;
  logic [7:0]        w_reload;
  logic [15:0]       w_lv_full;
  logic [NUM_IN-1:0] w_lv_new;
  logic [31:0]       w_rdata;
  logic [31:0]       w_sig;
  logic              w_misr_load, w_misr_step;
  logic              w_unused;

  assign w_off = wbs.wbs_adr_i[7:0];
  assign w_hit = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // Gating with r_ack splits a held strobe into separate single-ack accesses
  assign w_req = w_hit & ~r_ack;
  assign w_wr  = w_req & wbs.wbs_we_i;

  assign w_start  = w_wr & (w_off == OFF_CTRL) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[0];
  assign w_abort  = w_wr & (w_off == OFF_CTRL) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[1];
  assign w_busy   = (r_state == StSettle) | (r_state == StSample);
  assign w_reload = (r_settle == 8'd0) ? 8'd1 : r_settle;

  // Byte-lane merge for LAST_VEC writes
  always_comb begin
    w_lv_full = 16'(r_last_vec);
    if (wbs.wbs_sel_i[0]) w_lv_full[7:0] = wbs.wbs_dat_i[7:0];
    if (wbs.wbs_sel_i[1]) w_lv_full[15:8] = wbs.wbs_dat_i[15:8];
    w_lv_new = w_lv_full[NUM_IN-1:0];
  end

  // Read data mux; unmapped offsets return zero
  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      OFF_CTRL:     w_rdata = {30'b0, r_done, w_busy};
      OFF_SETTLE:   w_rdata = {24'b0, r_settle};
      OFF_LAST_VEC: w_rdata = 32'(r_last_vec);
      OFF_SIG:      w_rdata = w_sig;
      OFF_RESP:     w_rdata = 32'(r_resp);
      OFF_VEC:      w_rdata = 32'(r_vec);
      default:      w_rdata = 32'h0;
    endcase
  end

  // Bus ack and read data, valid for exactly one cycle per access
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~wbs.wbs_we_i) ? w_rdata : 32'h0;
    end
  end

  // Configuration registers, frozen while a sweep is running
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_settle   <= 8'd1;
      r_last_vec <= '1;
    end else if (w_wr & ~w_busy) begin
      if ((w_off == OFF_SETTLE) && wbs.wbs_sel_i[0]) r_settle <= wbs.wbs_dat_i[7:0];
      if (w_off == OFF_LAST_VEC) r_last_vec <= w_lv_new;
    end
  end

  // Sweep FSM next-state; ABORT overrides everything including START
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_vec_d     = r_vec;
    w_stim_d    = r_stim;
    w_resp_d    = r_resp;
    w_done_d    = r_done;
    w_misr_load = 1'b0;
    w_misr_step = 1'b0;
    if (w_abort) begin
      w_state_d = StIdle;
      w_stim_d  = '0;
      w_done_d  = 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (w_start) begin
            w_vec_d     = '0;
            w_stim_d    = '0;
            w_done_d    = 1'b0;
            w_cnt_d     = w_reload;
            w_misr_load = 1'b1;
            w_state_d   = StSettle;
          end
        end
        StSettle: begin
          if (r_cnt == 8'd1) begin
            w_state_d = StSample;
          end else begin
            w_cnt_d = r_cnt - 8'd1;
          end
        end
        StSample: begin
          w_resp_d    = resp_i;
          w_misr_step = 1'b1;
          // Terminal compare precedes the increment, so VEC never wraps
          if (r_vec == r_last_vec) begin
            w_state_d = StDone;
            w_done_d  = 1'b1;
          end else begin
            w_vec_d   = r_vec + 1'b1;
            w_stim_d  = r_vec + 1'b1;
            w_cnt_d   = w_reload;
            w_state_d = StSettle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Sweep FSM state and datapath registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
      r_vec   <= '0;
      r_stim  <= '0;
      r_resp  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_vec   <= w_vec_d;
      r_stim  <= w_stim_d;
      r_resp  <= w_resp_d;
      r_done  <= w_done_d;
    end
  end

  cell_stim_misr #(
    .SEED(SEED)
  ) u_misr (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_load  (w_misr_load),
    .i_step  (w_misr_step),
    .i_data  (32'(resp_i)),
    .o_sig   (w_sig)
  );

  assign stim_o        = r_stim;
  assign busy_o        = w_busy;
  assign done_o        = r_done;
  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;

  assign w_unused = ^{wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2], w_lv_full};

endmodule

// File: tb/tb_cell_stim_capture.sv
// Directed bench for cell_stim_capture: reset, sweeps, abort, async reset, bus timing.
module tb_cell_stim_capture;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_SET  = BASE + 32'h04;
  localparam logic [31:0] A_LV   = BASE + 32'h08;
  localparam logic [31:0] A_SIG  = BASE + 32'h0C;
  localparam logic [31:0] A_RESP = BASE + 32'h10;
  localparam logic [31:0] A_VEC  = BASE + 32'h14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] stim;
  logic [1:0] resp;
  logic       busy, done;
  logic       and_mode = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Cell-under-test model: 2-input AND on stim[1:0], or tied low
  assign resp = and_mode ? {1'b0, stim[1] & stim[0]} : 2'b00;

  cell_stim_capture_if u_bus ();

  cell_stim_capture #(
    .NUM_IN    (4),
    .NUM_OUT   (2),
    .BASE_ADDR (BASE),
    .SEED      (32'hFFFF_FFFF)
  ) u_dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs       (u_bus),
    .stim_o    (stim),
    .resp_i    (resp),
    .busy_o    (busy),
    .done_o    (done)
  );

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] d);
    return ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0)) ^ d;
  endfunction

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat, output logic ok);
    @(negedge clk);
    u_bus.wbs_stb_i = 1'b1;
    u_bus.wbs_cyc_i = 1'b1;
    u_bus.wbs_we_i  = we;
    u_bus.wbs_sel_i = 4'hF;
    u_bus.wbs_adr_i = adr;
    u_bus.wbs_dat_i = wdat;
    ok   = 1'b0;
    rdat = 32'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (u_bus.wbs_ack_o) begin
        ok   = 1'b1;
        rdat = u_bus.wbs_dat_o;
        break;
      end
    end
    u_bus.wbs_stb_i = 1'b0;
    u_bus.wbs_cyc_i = 1'b0;
    u_bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    logic ok;
    wb_access(1'b1, adr, dat, dummy, ok);
    if (!ok) begin
      n_total++;
      $display("FAIL bus_write_ack adr=%h: got no ack, want ack", adr);
    end
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    logic ok;
    wb_access(1'b0, adr, 32'h0, dat, ok);
    if (!ok) begin
      n_total++;
      $display("FAIL bus_read_ack adr=%h: got no ack, want ack", adr);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic ok;
    #2;
    n_total++; if (stim !== 4'h0) $display("FAIL rst_stim: got %h want 0", stim); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_total++; if (u_bus.wbs_ack_o !== 1'b0) $display("FAIL rst_ack: got %b want 0", u_bus.wbs_ack_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(A_CTRL, rd);
    n_total++; if (rd !== 32'h0) $display("FAIL rst_ctrl: got %h want 0", rd); else n_pass++;
    wb_read(A_SET, rd);
    n_total++; if (rd !== 32'h1) $display("FAIL rst_settle: got %h want 1", rd); else n_pass++;
    wb_read(A_LV, rd);
    n_total++; if (rd !== 32'hF) $display("FAIL rst_last_vec: got %h want f", rd); else n_pass++;
    wb_read(A_SIG, rd);
    n_total++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rst_sig: got %h want ffffffff", rd);
    else n_pass++;
    wb_read(BASE + 32'h18, rd);
    n_total++; if (rd !== 32'h0) $display("FAIL unmapped_read: got %h want 0", rd); else n_pass++;
    wb_access(1'b0, 32'h4000_0000, 32'h0, rd, ok);
    n_total++; if (ok !== 1'b0) $display("FAIL miss_no_ack: got ack=%b want 0", ok); else n_pass++;
  endtask

  task automatic test_single_vector();
    logic [31:0] rd;
    int cyc = 0;
    and_mode = 1'b0;
    wb_write(A_SET, 32'd3);
    wb_write(A_LV, 32'd0);
    wb_write(A_CTRL, 32'h1);
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    n_total++; if (cyc != 4) $display("FAIL single_busy_cycles: got %0d want 4", cyc); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL single_done: got %b want 1", done); else n_pass++;
    wb_read(A_SIG, rd);
    n_total++; if (rd !== 32'hFB3E_E249) $display("FAIL single_sig: got %h want fb3ee249", rd);
    else n_pass++;
    wb_read(A_VEC, rd);
    n_total++; if (rd !== 32'h0) $display("FAIL single_vec: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_two_vectors();
    logic [31:0] rd;
    logic [3:0] hist [8];
    int cyc = 0;
    wb_write(A_SET, 32'd0);
    wb_write(A_LV, 32'd1);
    wb_write(A_CTRL, 32'h1);
    while (busy && cyc < 8) begin
      hist[cyc] = stim;
      cyc++;
      @(negedge clk);
    end
    n_total++; if (cyc != 4) $display("FAIL two_busy_cycles: got %0d want 4", cyc); else n_pass++;
    n_total++;
    if ({hist[0], hist[1], hist[2], hist[3]} !== 16'h0011)
      $display("FAIL two_stim_seq: got %h%h%h%h want 0011", hist[0], hist[1], hist[2], hist[3]);
    else n_pass++;
    wb_read(A_SIG, rd);
    n_total++; if (rd !== 32'hF2BC_D925) $display("FAIL two_sig: got %h want f2bcd925", rd);
    else n_pass++;
    n_total++; if (stim !== 4'h1) $display("FAIL two_stim_hold: got %h want 1", stim); else n_pass++;
  endtask

  task automatic test_and_model();
    logic [31:0] rd;
    logic [31:0] exp_sig;
    int cyc = 0;
    exp_sig = 32'hFFFF_FFFF;
    for (int v = 0; v < 4; v++) exp_sig = ref_step(exp_sig, (v == 3) ? 32'h1 : 32'h0);
    and_mode = 1'b1;
    wb_write(A_SET, 32'd2);
    wb_write(A_LV, 32'd3);
    wb_write(A_CTRL, 32'h1);
    while (!done && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    n_total++; if (done !== 1'b1) $display("FAIL and_done: got %b want 1", done); else n_pass++;
    wb_read(A_RESP, rd);
    n_total++; if (rd !== 32'h1) $display("FAIL and_resp: got %h want 1", rd); else n_pass++;
    wb_read(A_SIG, rd);
    n_total++; if (rd !== exp_sig) $display("FAIL and_sig: got %h want %h", rd, exp_sig);
    else n_pass++;
    wb_read(A_VEC, rd);
    n_total++; if (rd !== 32'h3) $display("FAIL and_vec: got %h want 3", rd); else n_pass++;
    wb_read(A_CTRL, rd);
    n_total++; if (rd !== 32'h2) $display("FAIL and_ctrl: got %h want 2", rd); else n_pass++;
    n_total++; if (stim !== 4'h3) $display("FAIL and_stim_hold: got %h want 3", stim); else n_pass++;
    and_mode = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int cyc = 0;
    wb_write(A_CTRL, 32'h3);
    n_total++; if (busy !== 1'b0) $display("FAIL abort_start_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (stim !== 4'h0) $display("FAIL abort_start_stim: got %h want 0", stim); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL abort_start_done: got %b want 0", done); else n_pass++;
    wb_write(A_SET, 32'd5);
    wb_write(A_LV, 32'hF);
    wb_write(A_CTRL, 32'h1);
    while (stim != 4'h2 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    n_total++; if (stim !== 4'h2) $display("FAIL abort_reach_vec2: got %h want 2", stim); else n_pass++;
    wb_write(A_CTRL, 32'h1);
    n_total++; if (stim !== 4'h2) $display("FAIL busy_start_ignored: got %h want 2", stim);
    else n_pass++;
    wb_write(A_SET, 32'd9);
    wb_read(A_SET, rd);
    n_total++; if (rd !== 32'd5) $display("FAIL busy_settle_locked: got %h want 5", rd); else n_pass++;
    wb_write(A_CTRL, 32'h2);
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (stim !== 4'h0) $display("FAIL abort_stim: got %h want 0", stim); else n_pass++;
    wb_read(A_CTRL, rd);
    n_total++; if (rd !== 32'h0) $display("FAIL abort_ctrl: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    wb_write(A_SET, 32'd20);
    wb_write(A_LV, 32'd3);
    wb_write(A_CTRL, 32'h1);
    while (stim != 4'h1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    n_total++; if (stim !== 4'h1) $display("FAIL arst_reach_vec1: got %h want 1", stim); else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (stim !== 4'h0) $display("FAIL arst_stim: got %h want 0", stim); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else n_pass++;
    n_total++;
    if (u_dut.w_sig !== 32'hFFFF_FFFF) $display("FAIL arst_sig: got %h want ffffffff", u_dut.w_sig);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    u_bus.wbs_stb_i = 1'b1;
    u_bus.wbs_cyc_i = 1'b1;
    u_bus.wbs_we_i  = 1'b0;
    u_bus.wbs_sel_i = 4'hF;
    u_bus.wbs_adr_i = A_SET;
    @(negedge clk);
    n_total++;
    if (u_bus.wbs_ack_o !== 1'b1 || u_bus.wbs_dat_o !== 32'h1)
      $display("FAIL b2b_first: got ack=%b dat=%h want ack=1 dat=1", u_bus.wbs_ack_o, u_bus.wbs_dat_o);
    else n_pass++;
    u_bus.wbs_adr_i = A_LV;
    @(negedge clk);
    n_total++; if (u_bus.wbs_ack_o !== 1'b0) $display("FAIL b2b_gap: got ack=%b want 0",
                                                      u_bus.wbs_ack_o);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (u_bus.wbs_ack_o !== 1'b1 || u_bus.wbs_dat_o !== 32'hF)
      $display("FAIL b2b_second: got ack=%b dat=%h want ack=1 dat=f", u_bus.wbs_ack_o,
               u_bus.wbs_dat_o);
    else n_pass++;
    u_bus.wbs_stb_i = 1'b0;
    u_bus.wbs_cyc_i = 1'b0;
    @(negedge clk);
    n_total++; if (u_bus.wbs_ack_o !== 1'b0) $display("FAIL b2b_end: got ack=%b want 0",
                                                      u_bus.wbs_ack_o);
    else n_pass++;
  endtask

  initial begin
    u_bus.wbs_stb_i = 1'b0;
    u_bus.wbs_cyc_i = 1'b0;
    u_bus.wbs_we_i  = 1'b0;
    u_bus.wbs_sel_i = 4'h0;
    u_bus.wbs_adr_i = 32'h0;
    u_bus.wbs_dat_i = 32'h0;
    test_reset();
    test_single_vector();
    test_two_vectors();
    test_and_model();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
